// File: rtl/mem_access_stage.sv
// MEM stage: word-addressed data memory, branch resolution and the MEM/WB register.
// Optional build macro MEM_ALIGN_CHECK_EN enables misaligned-access detection.
module mem_access_stage #(
  parameter int DMEM_ADDR_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  wb_ctlout,
  input  logic [2:0]  m_ctlout,
  input  logic [31:0] alu_result,
  input  logic [31:0] rdata2out,
  input  logic        zero,
  input  logic [31:0] add_result,
  input  logic [4:0]  five_bit_muxout,
  output logic        pcsrc,
  output logic [31:0] branch_target,
  output logic [1:0]  mem_wb_ctl,
  output logic [31:0] mem_read_data,
  output logic [31:0] mem_alu_result,
  output logic [4:0]  mem_write_reg,
  output logic        misalign
);

  localparam int DEPTH = 2 ** DMEM_ADDR_W;

  logic [31:0]            r_mem [DEPTH];
  logic [1:0]             r_wb_ctl;
  logic [31:0]            r_read_data;
  logic [31:0]            r_alu_result;
  logic [4:0]             r_write_reg;
  logic                   r_misalign;

  logic                   w_branch;
  logic                   w_mem_read;
  logic                   w_mem_write;
  logic [DMEM_ADDR_W-1:0] w_idx;
  logic                   w_misalign;
  logic                   w_do_write;
  logic [31:0]            w_read_data;

  assign w_branch    = m_ctlout[2];
  assign w_mem_read  = m_ctlout[1];
  assign w_mem_write = m_ctlout[0];
  // Upper address bits are dropped, so addresses wrap modulo the memory depth.
  assign w_idx       = alu_result[DMEM_ADDR_W+1:2];

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = (w_mem_read | w_mem_write) & (alu_result[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  assign pcsrc         = w_branch & zero;
  assign branch_target = add_result;

  // Asynchronous read sees pre-write contents when read and write coincide.
  assign w_read_data = (w_mem_read && !w_misalign) ? r_mem[w_idx] : 32'h0;
  assign w_do_write  = w_mem_write & ~w_misalign & ~reset;

  always_ff @(posedge clk) begin
    if (w_do_write) begin
      r_mem[w_idx] <= rdata2out;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wb_ctl     <= 2'b00;
      r_read_data  <= 32'h0;
      r_alu_result <= 32'h0;
      r_write_reg  <= 5'd0;
      r_misalign   <= 1'b0;
    end else begin
      // A misaligned entry must not write back, so RegWrite is dropped.
      r_wb_ctl     <= {wb_ctlout[1] & ~w_misalign, wb_ctlout[0]};
      r_read_data  <= w_read_data;
      r_alu_result <= alu_result;
      r_write_reg  <= five_bit_muxout;
      r_misalign   <= w_misalign;
    end
  end

  assign mem_wb_ctl     = r_wb_ctl;
  assign mem_read_data  = r_read_data;
  assign mem_alu_result = r_alu_result;
  assign mem_write_reg  = r_write_reg;
  assign misalign       = r_misalign;

endmodule
